hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall and flush performance counters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 Rs1D, Rs2D  input  5 each  source register indices of the instruction in Decode.
REQ-005 Rs1E, Rs2E, RdE  input  5 each  source and destination indices of the instruction in Execute.
REQ-006 RdM, RdW  input  5 each  destination indices of the instructions in Memory and Writeback.
REQ-007 RegWriteM, RegWriteW  input  1 each  register-write enable of the instructions in Memory and Writeback.
REQ-008 ResultSrcE0  input  1  high when the instruction in Execute is a load.
REQ-009 PCSrcE  input  1  taken branch or jump resolved in Execute.
REQ-010 MemReqM  input  1  instruction in Memory accesses data memory.
REQ-011 MemReadyM  input  1  data memory completion strobe.
REQ-012 MemStartM  output  1  one-cycle pulse that launches a data-memory access.
REQ-013 ForwardAE, ForwardBE  output  2 each  ALU operand forwarding selects.
REQ-014 StallF, StallD, StallE, StallM  output  1 each  hold the stage register; 1 = hold.
REQ-015 FlushD, FlushE, FlushW  output  1 each  clear the stage register to a bubble.
REQ-016 stall_cycles, flush_cycles  output  CNT_W each  performance counters.

Function
REQ-017 ForwardAE SHALL be 2'b10 when RegWriteM=1, RdM!=0 and RdM==Rs1E; otherwise 2'b01 when RegWriteW=1, RdW!=0 and RdW==Rs1E; otherwise 2'b00. The result SHALL be combinational.
REQ-018 ForwardBE SHALL use the same rules as REQ-017, with Rs2E in place of Rs1E.
REQ-019 lwStall SHALL be defined as ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-020 The FSM SHALL have two states, RUN and WAIT.
  - RUN with MemReqM=1: next state WAIT; MemStartM=1 in this cycle.
  - WAIT with MemReadyM=1: next state RUN.
  - All other cases: hold the current state.
REQ-021 MemReadyM SHALL be ignored in RUN, so every memory access occupies Memory for at least 2 cycles.
REQ-022 memStall SHALL be defined as (RUN && MemReqM) || (WAIT && !MemReadyM).
REQ-023 When memStall=1, the outputs SHALL be:
  - StallF=StallD=StallE=StallM=1.
  - FlushW=1.
  - FlushD=FlushE=0; this overrides both lwStall and PCSrcE.
REQ-024 When memStall=0, the outputs SHALL be:
  - StallF=StallD=lwStall.
  - StallE=StallM=0, FlushW=0.
  - FlushD=PCSrcE.
  - FlushE=lwStall||PCSrcE.
REQ-025 When lwStall and PCSrcE are both 1 with memStall=0, REQ-024 SHALL apply unchanged.
REQ-026 stall_cycles SHALL increment on each clock edge where StallF=1.
REQ-027 flush_cycles SHALL increment on each clock edge where FlushD=1.
REQ-028 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-029 On a clock edge with reset=0, the FSM SHALL enter RUN and both counters SHALL become 0.
REQ-030 While reset=0, the outputs SHALL be:
  - All Stall outputs 0.
  - FlushD=FlushE=FlushW=1.
  - MemStartM=0.
  - ForwardAE=ForwardBE=2'b00.
REQ-031 A reset during WAIT SHALL abandon the access; the first cycle after reset SHALL be in RUN.

Structure
REQ-032 Shared package hazard_pkg SHALL hold:
  - the state enum {RUN, WAIT};
  - the forwarding encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
REQ-033 Sub-module sat_counter (parameter width, with clk, reset, inc and count ports) SHALL be instantiated twice, once per performance counter.
REQ-034 The forwarding and stall/flush decode SHALL be combinational; the FSM and the counters are the only state.

Verification
REQ-035 Forwarding priority: set Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1.
  - Required: ForwardAE=10.
  - Then set RegWriteM=0: required ForwardAE=01.
  - Then set RdM=RdW=0 with both writes enabled: required ForwardAE=00.
REQ-036 Load-use: set ResultSrcE0=1, RdE=7, Rs2D=7.
  - Required: StallF=StallD=1, FlushE=1, FlushD=0, and stall_cycles +1 per cycle.
  - Repeat with RdE=0: required no stall.
REQ-037 Branch: set PCSrcE=1 with no load.
  - Required: FlushD=FlushE=1, StallF=0, and flush_cycles +1.
REQ-038 Memory wait: hold MemReqM=1 and assert MemReadyM in the 4th cycle.
  - Required: MemStartM=1 in cycle 1 only.
  - Required: all Stall outputs and FlushW=1 in cycles 1-3; all 0 in cycle 4.
  - Required: stall_cycles +3.
  - Required: PCSrcE=1 during cycles 1-3 produces no FlushD.
REQ-039 Reset in WAIT: pull reset=0 for one edge during a pending access.
  - Required: FSM in RUN, counters 0, all flushes 1 while reset is low.
  - Required: after release with MemReqM=1, MemStartM pulses again.
REQ-040 Saturation: build with CNT_W=4 and hold lwStall for 20 cycles.
  - Required: stall_cycles=15 and holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and forwarding encodings for the hazard unit
package hazard_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // Memory beats Writeback because it holds the younger value of the register.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m, input logic we_m,
                                          input logic [4:0] rd_w, input logic we_w);
      if (we_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_M;
      if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_W;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_unit_if #(parameter int CNT_W = 16);

   logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic             RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
   logic             MemReqM, MemReadyM, MemStartM;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic [CNT_W-1:0] stall_cycles, flush_cycles;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
      input  MemStartM, ForwardAE, ForwardBE,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      input  stall_cycles, flush_cycles
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
      output MemStartM, ForwardAE, ForwardBE,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      output stall_cycles, flush_cycles
   );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones
module sat_counter #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [width-1:0] count
);

   logic [width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {width{1'b1}}))
         count_d = count_q + {{(width-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, load-use/branch hazards and data-memory wait control
import hazard_pkg::*;

module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         reset,
   hazard_unit_if.slave hz
);

   state_e           state_q, state_d;
   logic             lw_stall, mem_stall, stall_f, flush_d;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (hz.MemReqM)   state_d = WAIT;
         WAIT:    if (hz.MemReadyM) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      lw_stall  = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                  ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
      // Ready is ignored in RUN, so every access holds Memory for two cycles minimum.
      mem_stall = ((state_q == RUN) && hz.MemReqM) ||
                  ((state_q == WAIT) && !hz.MemReadyM);

      stall_f      = 1'b0;
      flush_d      = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallM    = 1'b0;
      hz.FlushE    = 1'b0;
      hz.FlushW    = 1'b0;
      hz.MemStartM = 1'b0;
      hz.ForwardAE = FWD_RF;
      hz.ForwardBE = FWD_RF;

      if (!reset) begin
         flush_d   = 1'b1;
         hz.FlushE = 1'b1;
         hz.FlushW = 1'b1;
      end else begin
         hz.MemStartM = (state_q == RUN) && hz.MemReqM;
         hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
         hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
         if (mem_stall) begin
            // Freeze the whole pipe; a pending branch or load-use waits its turn.
            stall_f   = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
         end else begin
            stall_f   = lw_stall;
            hz.StallD = lw_stall;
            flush_d   = hz.PCSrcE;
            hz.FlushE = lw_stall || hz.PCSrcE;
         end
      end

      hz.StallF = stall_f;
      hz.FlushD = flush_d;
   end

   sat_counter #(.width(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_f),
      .count (stall_cnt)
   );

   sat_counter #(.width(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_d),
      .count (flush_cnt)
   );

   assign hz.stall_cycles = stall_cnt;
   assign hz.flush_cycles = flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

   logic clk = 1'b0;
   logic reset;
   logic rst4;

   hazard_unit_if #(.CNT_W(16)) hz ();
   hazard_unit_if #(.CNT_W(4))  hz4 ();

   hazard_unit #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .hz(hz.slave));
   hazard_unit #(.CNT_W(4))  dut4 (.clk(clk), .reset(rst4),  .hz(hz4.slave));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: is an access outstanding, and the two counter values.
   bit m_busy;
   int m_stall, m_flush;
   int e_fa, e_fb, e_stall, e_flush, e_start;

   typedef struct {
      string      name;
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rwm, rww, lde, pcs;
      int         fa, fb, stall, flush;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_fwd(input logic [4:0] rs);
      if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2;
      if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 1;
      return 0;
   endfunction

   task automatic model_eval();
      bit lw, mem;
      lw  = hz.ResultSrcE0 && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
      mem = m_busy ? !hz.MemReadyM : hz.MemReqM;
      if (!reset) begin
         e_fa = 0; e_fb = 0; e_stall = 0; e_flush = 7; e_start = 0;
      end else begin
         e_fa    = ref_fwd(hz.Rs1E);
         e_fb    = ref_fwd(hz.Rs2E);
         e_start = (!m_busy && hz.MemReqM) ? 1 : 0;
         if (mem) begin
            e_stall = 15; e_flush = 1;
         end else begin
            e_stall = lw ? 12 : 0;
            e_flush = (hz.PCSrcE ? 4 : 0) + ((lw || hz.PCSrcE) ? 2 : 0);
         end
      end
   endtask

   function automatic int stall_vec();
      return {28'd0, hz.StallF, hz.StallD, hz.StallE, hz.StallM};
   endfunction

   function automatic int flush_vec();
      return {29'd0, hz.FlushD, hz.FlushE, hz.FlushW};
   endfunction

   task automatic check_all(input string tag);
      model_eval();
      chk({tag, ".fa"},    hz.ForwardAE, e_fa);
      chk({tag, ".fb"},    hz.ForwardBE, e_fb);
      chk({tag, ".stall"}, stall_vec(), e_stall);
      chk({tag, ".flush"}, flush_vec(), e_flush);
      chk({tag, ".start"}, hz.MemStartM, e_start);
      chk({tag, ".scnt"},  hz.stall_cycles, m_stall);
      chk({tag, ".fcnt"},  hz.flush_cycles, m_flush);
   endtask

   task automatic tick();
      model_eval();
      if (!reset) begin
         m_busy = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (e_stall[3] && m_stall < 65535) m_stall++;
         if (e_flush[2] && m_flush < 65535) m_flush++;
         if (!m_busy && hz.MemReqM)     m_busy = 1;
         else if (m_busy && hz.MemReadyM) m_busy = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
      hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
      hz.RegWriteM = 0; hz.RegWriteW = 0; hz.ResultSrcE0 = 0;
      hz.PCSrcE = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
   endtask

   task automatic add(input string n, input int rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                      input int rwm, rww, lde, pcs, fa, fb, st, fl);
      vec_t v;
      v.name = n; v.rs1d = rs1d[4:0]; v.rs2d = rs2d[4:0]; v.rs1e = rs1e[4:0];
      v.rs2e = rs2e[4:0]; v.rde = rde[4:0]; v.rdm = rdm[4:0]; v.rdw = rdw[4:0];
      v.rwm = rwm[0]; v.rww = rww[0]; v.lde = lde[0]; v.pcs = pcs[0];
      v.fa = fa; v.fb = fb; v.stall = st; v.flush = fl;
      vecs.push_back(v);
   endtask

   initial begin
      int base_s, base_f;
      reset = 0; rst4 = 0;
      idle();
      hz4.Rs1D = 0; hz4.Rs2D = 0; hz4.Rs1E = 0; hz4.Rs2E = 0;
      hz4.RdE = 0; hz4.RdM = 0; hz4.RdW = 0;
      hz4.RegWriteM = 0; hz4.RegWriteW = 0; hz4.ResultSrcE0 = 0;
      hz4.PCSrcE = 0; hz4.MemReqM = 0; hz4.MemReadyM = 0;
      m_busy = 0; m_stall = 0; m_flush = 0;
      tick();
      tick();
      check_all("reset");
      reset = 1;
      #1;
      check_all("idle");

      //    name       rs1d rs2d rs1e rs2e rde rdm rdw rwm rww lde pcs fa fb stall flush
      add("fwd_m",      0,   0,   5,   0,   0,  5,  5,  1,  1,  0,  0, 2, 0,  0,   0);
      add("fwd_w",      0,   0,   5,   0,   0,  5,  5,  0,  1,  0,  0, 1, 0,  0,   0);
      add("fwd_x0",     0,   0,   5,   0,   0,  0,  0,  1,  1,  0,  0, 0, 0,  0,   0);
      add("fwd_x0rs",   0,   0,   0,   0,   0,  0,  0,  1,  1,  0,  0, 0, 0,  0,   0);
      add("fwd_b_m",    0,   0,   1,   9,   0,  9,  9,  1,  1,  0,  0, 0, 2,  0,   0);
      add("fwd_b_w",    0,   0,   3,   9,   0,  3,  9,  1,  1,  0,  0, 2, 1,  0,   0);
      add("lu_rs2",     0,   7,   0,   0,   7,  0,  0,  0,  0,  1,  0, 0, 0, 12,   2);
      add("lu_rs1",    12,   0,   0,   0,  12,  0,  0,  0,  0,  1,  0, 0, 0, 12,   2);
      add("lu_x0",      0,   0,   0,   0,   0,  0,  0,  0,  0,  1,  0, 0, 0,  0,   0);
      add("no_load",    0,   7,   0,   0,   7,  0,  0,  0,  0,  0,  0, 0, 0,  0,   0);
      add("branch",     0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  1, 0, 0,  0,   6);
      add("lu_branch",  0,   7,   0,   0,   7,  0,  0,  0,  0,  1,  1, 0, 0, 12,   6);

      foreach (vecs[i]) begin
         hz.Rs1D = vecs[i].rs1d; hz.Rs2D = vecs[i].rs2d; hz.Rs1E = vecs[i].rs1e;
         hz.Rs2E = vecs[i].rs2e; hz.RdE = vecs[i].rde; hz.RdM = vecs[i].rdm;
         hz.RdW = vecs[i].rdw; hz.RegWriteM = vecs[i].rwm; hz.RegWriteW = vecs[i].rww;
         hz.ResultSrcE0 = vecs[i].lde; hz.PCSrcE = vecs[i].pcs;
         #1;
         chk({vecs[i].name, ".fa"},    hz.ForwardAE, vecs[i].fa);
         chk({vecs[i].name, ".fb"},    hz.ForwardBE, vecs[i].fb);
         chk({vecs[i].name, ".stall"}, stall_vec(), vecs[i].stall);
         chk({vecs[i].name, ".flush"}, flush_vec(), vecs[i].flush);
         base_s = m_stall; base_f = m_flush;
         tick();
         chk({vecs[i].name, ".scnt"}, hz.stall_cycles, base_s + (vecs[i].stall >= 8 ? 1 : 0));
         chk({vecs[i].name, ".fcnt"}, hz.flush_cycles, base_f + (vecs[i].flush >= 4 ? 1 : 0));
      end

      // Memory access with ready in the fourth cycle and a branch pending meanwhile.
      idle();
      #1;
      base_s = m_stall; base_f = m_flush;
      hz.MemReqM = 1;
      for (int c = 1; c <= 4; c++) begin
         hz.PCSrcE    = (c < 4);
         hz.MemReadyM = (c == 4);
         #1;
         chk($sformatf("mem_c%0d.start", c), hz.MemStartM, (c == 1));
         chk($sformatf("mem_c%0d.stall", c), stall_vec(), (c < 4) ? 15 : 0);
         chk($sformatf("mem_c%0d.flush", c), flush_vec(), (c < 4) ? 1 : 0);
         tick();
      end
      idle();
      #1;
      chk("mem.scnt", hz.stall_cycles, base_s + 3);
      chk("mem.fcnt", hz.flush_cycles, base_f);

      // Reset while an access is outstanding.
      hz.MemReqM = 1;
      tick();
      chk("rw.wait_start", hz.MemStartM, 0);
      hz.Rs1E = 5; hz.RdM = 5; hz.RegWriteM = 1;
      reset = 0;
      #1;
      chk("rw.stall", stall_vec(), 0);
      chk("rw.flush", flush_vec(), 7);
      chk("rw.start", hz.MemStartM, 0);
      chk("rw.fa", hz.ForwardAE, 0);
      tick();
      chk("rw.scnt", hz.stall_cycles, 0);
      chk("rw.fcnt", hz.flush_cycles, 0);
      reset = 1;
      #1;
      chk("rw.restart", hz.MemStartM, 1);
      check_all("rw.after");
      tick();
      hz.MemReadyM = 1;
      tick();
      idle();
      #1;

      // Randomised traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
         hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
         hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
         hz.RdW  = 5'($urandom_range(0, 3));
         hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
         hz.ResultSrcE0 = 1'($urandom); hz.PCSrcE = ($urandom_range(0, 3) == 0);
         hz.MemReqM = ($urandom_range(0, 3) == 0); hz.MemReadyM = 1'($urandom);
         reset = ($urandom_range(0, 39) != 0);
         #1;
         check_all($sformatf("rnd%0d", n));
         tick();
      end
      reset = 1;

      // Narrow counter saturation on the second instance.
      hz4.ResultSrcE0 = 1; hz4.RdE = 3; hz4.Rs1D = 3;
      rst4 = 0;
      @(posedge clk); #1;
      rst4 = 1;
      chk("sat.start", hz4.stall_cycles, 0);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == 14) chk("sat.c14", hz4.stall_cycles, 14);
      end
      chk("sat.c20", hz4.stall_cycles, 15);
      repeat (5) @(posedge clk);
      #1;
      chk("sat.hold", hz4.stall_cycles, 15);
      chk("sat.fcnt", hz4.flush_cycles, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
